// File: rtl/facto_pkg.sv
// ---------------------------------------------------------------------------
// facto_pkg : shared widths and FSM encoding for the factorial datapath
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package facto_pkg;

  localparam int FACTO_WIDTH = 64;
  localparam int FACTO_ITER  = FACTO_WIDTH / 2;
  localparam int FACTO_CNT_W = $clog2(FACTO_ITER);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mul_pp_sel.sv
// ---------------------------------------------------------------------------
// mul_pp_sel : radix-4 partial-product mux selecting 0, M, 2M or 3M
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_pp_sel #(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH+1:0] m3,
  output logic [WIDTH+1:0] pp
);

  always_comb begin
    case (sel)
      2'b00:   pp = '0;
      2'b01:   pp = {2'b00, m};
      2'b10:   pp = {1'b0, m, 1'b0};
      default: pp = m3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/facto_multiplier.sv
// ---------------------------------------------------------------------------
// facto_multiplier : sequential radix-4 shift-add unsigned WIDTH x WIDTH mult
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module facto_multiplier
  import facto_pkg::*;
#(
  parameter int WIDTH = FACTO_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 opstart,
  input  logic                 opclear,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 opdone,
  output logic [2*WIDTH-1:0]   result
);

  localparam int ITER  = WIDTH / 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  logic [1:0]         state_q,  state_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH+1:0]   m3_q,     m3_d;
  logic [WIDTH+1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q,   done_d;

  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   sum;

  mul_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .sel (lo_q[1:0]),
    .m   (mcand_q),
    .m3  (m3_q),
    .pp  (pp)
  );

  // hi_q stays below M after each shift, so hi_q + 3M always fits WIDTH+2 bits.
  assign sum = hi_q + pp;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    m3_d     = m3_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;

    if (opclear) begin
      state_d  = ST_IDLE;
      mcand_d  = '0;
      m3_d     = '0;
      hi_d     = '0;
      lo_d     = '0;
      cnt_d    = '0;
      result_d = '0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (opstart) begin
            mcand_d = multiplicand;
            m3_d    = {2'b00, multiplicand} + {1'b0, multiplicand, 1'b0};
            hi_d    = '0;
            lo_d    = multiplier;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          hi_d  = {2'b00, sum[WIDTH+1:2]};
          lo_d  = {sum[1:0], lo_q[WIDTH-1:2]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = {sum, lo_q[WIDTH-1:2]};
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      m3_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      m3_q     <= m3_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign opdone = done_q;
  assign result = result_q;

endmodule

`default_nettype wire
